// File: rtl/bsg_wormhole_two_net_link_arbiter_pkg.sv
// Shared wormhole header geometry used by the bridge, link arbiter and demux.
// Header sits at the top of the first flit as {reserved, x, y, len}.
package bsg_wormhole_two_net_link_arbiter_pkg;

  localparam int wh_flit_width_gp     = 32;
  localparam int wh_len_width_gp      = 4;
  localparam int wh_x_cord_width_gp   = 3;
  localparam int wh_y_cord_width_gp   = 3;
  localparam int wh_reserved_width_gp = 2;

  function automatic int wh_hdr_width(
    input int reserved_w,
    input int len_w,
    input int x_w,
    input int y_w
  );
    return reserved_w + len_w + x_w + y_w;
  endfunction

  localparam int wh_hdr_width_gp = wh_hdr_width(
    wh_reserved_width_gp, wh_len_width_gp,
    wh_x_cord_width_gp, wh_y_cord_width_gp);

  localparam int wh_len_lsb_gp = wh_flit_width_gp - wh_hdr_width_gp;

endpackage

// File: rtl/bsg_wormhole_two_net_link_arbiter.sv
// Packet-granular round-robin merge of the request and response wormhole
// nets onto one link; every flit is tagged with the net that owns it.
module bsg_wormhole_two_net_link_arbiter
  import bsg_wormhole_two_net_link_arbiter_pkg::*;
#(
  parameter int width_p          = wh_flit_width_gp,
  parameter int len_width_p      = wh_len_width_gp,
  parameter int x_cord_width_p   = wh_x_cord_width_gp,
  parameter int y_cord_width_p   = wh_y_cord_width_gp,
  parameter int reserved_width_p = wh_reserved_width_gp,
  parameter int count_width_p    = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [1:0]                    valid_i,
  input  logic [1:0][width_p-1:0]       data_i,
  output logic [1:0]                    ready_o,
  output logic                          valid_o,
  output logic [width_p-1:0]            data_o,
  output logic                          net_id_o,
  input  logic                          yumi_i,
  output logic [1:0][count_width_p-1:0] pkt_count_o
);

  localparam int hdr_w = wh_hdr_width(
    reserved_width_p, len_width_p,
    x_cord_width_p, y_cord_width_p);
  localparam int len_lsb = width_p - hdr_w;

  localparam logic [len_width_p-1:0]   len_one = 1;
  localparam logic [count_width_p-1:0] cnt_one = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e state_r, state_n;

  logic                             last_r;
  logic                             owner_r;
  logic [len_width_p-1:0]           rem_r;
  logic [1:0][count_width_p-1:0]    cnt_r;

  logic                   grant;
  logic                   accept;
  logic                   tail;
  logic [len_width_p-1:0] hdr_len;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  assign hdr_len = data_o[len_lsb +: len_width_p];
  assign accept  = valid_o & yumi_i;

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE: if (accept && hdr_len != '0) state_n = BUSY;
      BUSY: if (accept && rem_r == len_one) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Grant is free to move in IDLE until a header is taken.
  always_comb begin
    grant   = owner_r;
    valid_o = 1'b0;
    unique case (state_r)
      IDLE: begin
        valid_o = |valid_i;
        case (valid_i)
          2'b01:   grant = 1'b0;
          2'b10:   grant = 1'b1;
          default: grant = ~last_r;
        endcase
      end
      BUSY: begin
        grant   = owner_r;
        valid_o = valid_i[owner_r];
      end
      default: begin
        grant   = owner_r;
        valid_o = 1'b0;
      end
    endcase
    data_o   = data_i[grant];
    net_id_o = grant;
    ready_o  = {yumi_i & grant, yumi_i & ~grant};
  end

  assign tail = accept &
    (((state_r == IDLE) && (hdr_len == '0)) ||
     ((state_r == BUSY) && (rem_r == len_one)));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_r  <= 1'b1;
      owner_r <= 1'b0;
      rem_r   <= '0;
    end else if (accept) begin
      if (state_r == IDLE) begin
        if (hdr_len == '0) begin
          last_r <= grant;
        end else begin
          owner_r <= grant;
          rem_r   <= hdr_len;
        end
      end else begin
        rem_r <= rem_r - len_one;
        if (rem_r == len_one) last_r <= owner_r;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (tail && (grant == i[0]) && (cnt_r[i] != '1))
          cnt_r[i] <= cnt_r[i] + cnt_one;
      end
    end
  end

  assign pkt_count_o = cnt_r;

endmodule

// File: tb/tb_bsg_wormhole_two_net_link_arbiter.sv
// Vector table plus scoreboard bench for the two-net link arbiter.
// Headers use len at bits [23:20] of a 32-bit flit.
module tb_bsg_wormhole_two_net_link_arbiter;

  localparam int W = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [1:0]          valid_i;
  logic [1:0][W-1:0]   data_i;
  logic [1:0]          ready_o;
  logic                valid_o;
  logic [W-1:0]        data_o;
  logic                net_id_o;
  logic                yumi_i;
  logic [1:0][15:0]    pkt_count_o;

  bsg_wormhole_two_net_link_arbiter #(
    .width_p(W),
    .len_width_p(4),
    .x_cord_width_p(3),
    .y_cord_width_p(3),
    .reserved_width_p(2),
    .count_width_p(16)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .valid_i(valid_i),
    .data_i(data_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .data_o(data_o),
    .net_id_o(net_id_o),
    .yumi_i(yumi_i),
    .pkt_count_o(pkt_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string        name;
    logic [1:0]   v;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         y;
    logic         vo;
    logic         nid;
    logic [1:0]   rdy;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic logic [W-1:0] hdr(int len, int tag);
    return (W'(len) << 20) | W'(tag);
  endfunction

  function automatic void add(string n, logic [1:0] v,
      logic [W-1:0] d0, logic [W-1:0] d1, logic y,
      logic vo, logic nid, logic [1:0] rdy);
    vec_t e;
    e.name = n; e.v = v; e.d0 = d0; e.d1 = d1; e.y = y;
    e.vo = vo; e.nid = nid; e.rdy = rdy;
    tbl.push_back(e);
  endfunction

  task automatic chk(string n, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  task automatic chk_cnt(string n, int c0, int c1);
    chk({n, "_cnt0"}, W'(pkt_count_o[0]), W'(c0));
    chk({n, "_cnt1"}, W'(pkt_count_o[1]), W'(c1));
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) begin
      valid_i   = tbl[i].v;
      data_i[0] = tbl[i].d0;
      data_i[1] = tbl[i].d1;
      yumi_i    = tbl[i].y;
      sb.push_back(tbl[i]);
      @(negedge clk);
      begin
        vec_t x;
        x = sb.pop_front();
        chk({x.name, "_valid"}, W'(valid_o), W'(x.vo));
        chk({x.name, "_ready"}, W'(ready_o), W'(x.rdy));
        if (x.vo) begin
          chk({x.name, "_netid"}, W'(net_id_o), W'(x.nid));
          chk({x.name, "_data"}, data_o, x.nid ? x.d1 : x.d0);
        end
      end
      @(posedge clk);
      #1;
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk_cnt("reset", 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int i0, i1, nid;
    valid_i = 2'b01;
    data_i  = '0;
    data_i[0] = hdr(0, 8'h01);
    yumi_i  = 1'b0;
    #1 rst_n = 1'b0;
    add("in_reset", 2'b01, hdr(0, 8'h01), '0, 1'b0, 1'b1, 1'b0, 2'b00);
    run_tbl();
    chk_cnt("reset_state", 0, 0);
    rst_n = 1'b1;

    add("single", 2'b01, hdr(0, 8'h0A), '0, 1'b1, 1'b1, 1'b0, 2'b01);
    add("idle", 2'b00, '0, '0, 1'b0, 1'b0, 1'b0, 2'b00);
    run_tbl();
    chk_cnt("single", 1, 0);

    add("lock_h", 2'b11, hdr(0, 8'hB0), hdr(3, 8'hC0), 1'b1, 1'b1, 1'b1, 2'b10);
    add("lock_b1", 2'b11, hdr(0, 8'hB0), W'(8'hC1), 1'b1, 1'b1, 1'b1, 2'b10);
    add("lock_b2", 2'b11, hdr(0, 8'hB0), W'(8'hC2), 1'b1, 1'b1, 1'b1, 2'b10);
    add("lock_t", 2'b11, hdr(0, 8'hB0), W'(8'hC3), 1'b1, 1'b1, 1'b1, 2'b10);
    add("lock_n0", 2'b11, hdr(0, 8'hB0), hdr(0, 8'hD0), 1'b1, 1'b1, 1'b0, 2'b01);
    run_tbl();
    chk_cnt("lock", 2, 1);

    do_reset();
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 8; k++) begin
      nid = (k >> 1) & 1;
      add("rr", 2'b11,
          (i0 % 2 == 0) ? hdr(1, 8'h40 + i0) : W'(8'h40 + i0),
          (i1 % 2 == 0) ? hdr(1, 8'h60 + i1) : W'(8'h60 + i1),
          1'b1, 1'b1, nid[0], nid[0] ? 2'b10 : 2'b01);
      if (nid == 0) i0++;
      else          i1++;
    end
    run_tbl();
    chk_cnt("rr", 2, 2);

    add("stall_h", 2'b11, hdr(2, 8'hE0), hdr(0, 8'hF0), 1'b1, 1'b1, 1'b0, 2'b01);
    for (int k = 0; k < 3; k++)
      add("stall_gap", 2'b10, W'(8'hE1), hdr(0, 8'hF0), 1'b0, 1'b0, 1'b0, 2'b00);
    add("stall_b", 2'b11, W'(8'hE1), hdr(0, 8'hF0), 1'b1, 1'b1, 1'b0, 2'b01);
    add("stall_t", 2'b11, W'(8'hE2), hdr(0, 8'hF0), 1'b1, 1'b1, 1'b0, 2'b01);
    add("stall_n1", 2'b11, hdr(0, 8'hE8), hdr(0, 8'hF0), 1'b1, 1'b1, 1'b1, 2'b10);
    run_tbl();
    chk_cnt("stall", 3, 3);

    add("bp_h", 2'b01, hdr(2, 8'h90), '0, 1'b1, 1'b1, 1'b0, 2'b01);
    for (int k = 0; k < 5; k++)
      add("bp_hold", 2'b01, W'(8'h91), '0, 1'b0, 1'b1, 1'b0, 2'b00);
    add("bp_b", 2'b01, W'(8'h91), '0, 1'b1, 1'b1, 1'b0, 2'b01);
    add("bp_t", 2'b11, W'(8'h92), hdr(0, 8'h93), 1'b1, 1'b1, 1'b0, 2'b01);
    add("bp_next", 2'b11, hdr(0, 8'h94), hdr(0, 8'h93), 1'b1, 1'b1, 1'b1, 2'b10);
    run_tbl();
    chk_cnt("bp", 4, 4);

    for (int f = 0; f < 16; f++)
      add("maxlen", 2'b10, '0, (f == 0) ? hdr(15, 8'h70) : W'(8'h70 + f),
          1'b1, 1'b1, 1'b1, 2'b10);
    add("maxlen_idle", 2'b00, '0, '0, 1'b0, 1'b0, 1'b0, 2'b00);
    run_tbl();
    chk_cnt("maxlen", 4, 5);

    add("rstmid_h", 2'b01, hdr(3, 8'hA0), '0, 1'b1, 1'b1, 1'b0, 2'b01);
    run_tbl();
    do_reset();
    add("rstmid_n1", 2'b10, W'(8'hA1), hdr(0, 8'hB5), 1'b1, 1'b1, 1'b1, 2'b10);
    run_tbl();
    chk_cnt("rstmid", 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
